// File: rtl/memory_ctrl_if.sv
// memory_ctrl_if: request/response bus between a requester (master) and memory_ctrl (slave)
// Signals: req, we, size[1:0], unsigned_ld, addr[ADDR_W-1:0], wdata[31:0] (master -> slave);
//          ready, done, rdata[31:0], err (slave -> master; err only with MEMORY_CTRL_MISALIGN_ERR_EN).
interface memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic req, we, unsigned_ld, ready, done;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rdata;
`ifdef MEMORY_CTRL_MISALIGN_ERR_EN
  logic err;
  modport master (output req, we, size, unsigned_ld, addr, wdata, input ready, done, rdata, err);
  modport slave (input req, we, size, unsigned_ld, addr, wdata, output ready, done, rdata, err);
`else
  modport master (output req, we, size, unsigned_ld, addr, wdata, input ready, done, rdata);
  modport slave (input req, we, size, unsigned_ld, addr, wdata, output ready, done, rdata);
`endif
endinterface

// File: rtl/memory_ctrl.sv
// memory_ctrl: byte-addressed little-endian RAM with a fixed-latency load/store handshake
// Ports: clk; resetn (asynchronous, active-low); bus (memory_ctrl_if.slave):
//   req/we/size/unsigned_ld/addr/wdata in, ready/done/rdata out, err out with the macro below.
// Macro MEMORY_CTRL_MISALIGN_ERR_EN: misaligned half/word accesses write nothing and
//   complete with err=1, rdata=0; without it they proceed byte-wise with address wrap.
module memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic resetn,
  memory_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic ready_q, done_q;
  logic [31:0] rdata_q;
  logic we_q, uns_q;
  logic [1:0] size_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0] wdata_q;
  logic a_we, a_uns;
  logic [1:0] a_size;
  logic [IDX_W-1:0] a_idx;
  logic [31:0] a_wdata;
  logic accept, commit, is_byte, is_half, mis;
  logic [7:0] mem [DEPTH_BYTES];
  logic [7:0] b [4];
  logic [31:0] ld_val;
  logic unused_addr;
  assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W];
  assign accept = state == IDLE && bus.req;
  // A zero-wait access completes on its accepting edge, so the live bus fields are used then
  assign a_we = state == IDLE ? bus.we : we_q;
  assign a_uns = state == IDLE ? bus.unsigned_ld : uns_q;
  assign a_size = state == IDLE ? bus.size : size_q;
  assign a_idx = state == IDLE ? bus.addr[IDX_W-1:0] : idx_q;
  assign a_wdata = state == IDLE ? bus.wdata : wdata_q;
  assign commit = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  assign is_byte = a_size == 2'b00;
  assign is_half = a_size == 2'b01;
`ifdef MEMORY_CTRL_MISALIGN_ERR_EN
  logic err_q;
  assign mis = (is_half && a_idx[0]) || (!is_byte && !is_half && a_idx[1:0] != 2'b00);
  assign bus.err = err_q;
`else
  assign mis = 1'b0;
`endif
  // Index arithmetic is IDX_W wide so multi-byte accesses wrap past the top of the array
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign b[k] = mem[a_idx + IDX_W'(k)];
  end
  assign ld_val = is_byte ? {{24{b[0][7] & ~a_uns}}, b[0]} :
                  is_half ? {{16{b[1][7] & ~a_uns}}, b[1], b[0]} :
                            {b[3], b[2], b[1], b[0]};
  assign bus.ready = ready_q;
  assign bus.done = done_q;
  assign bus.rdata = rdata_q;
  always_ff @(posedge clk)
    if (accept) begin
      we_q <= bus.we;
      uns_q <= bus.unsigned_ld;
      size_q <= bus.size;
      idx_q <= bus.addr[IDX_W-1:0];
      wdata_q <= bus.wdata;
    end
  // resetn gating keeps an edge coinciding with reset from committing a store
  always_ff @(posedge clk)
    if (resetn && commit && a_we && !mis)
      for (int k = 0; k < 4; k++)
        if (k == 0 || (k == 1 && !is_byte) || (k > 1 && !is_byte && !is_half))
          mem[a_idx + IDX_W'(k)] <= a_wdata[8*k +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= 4'd0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      rdata_q <= 32'd0;
`ifdef MEMORY_CTRL_MISALIGN_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      done_q <= commit;
      case (state)
        IDLE: if (bus.req) begin
          state <= WAIT_CYCLES == 0 ? DONE : WAIT;
          cnt <= WAIT_LOAD;
          ready_q <= 1'b0;
        end
        WAIT: if (cnt == 4'd0) state <= DONE;
              else cnt <= cnt - 4'd1;
        default: begin
          state <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
      if (commit) begin
        if (mis) rdata_q <= 32'd0;
        else if (!a_we) rdata_q <= ld_val;
`ifdef MEMORY_CTRL_MISALIGN_ERR_EN
        err_q <= mis;
`endif
      end
    end
endmodule
